mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Word-level request scheduler between the three memory clients (instruction fetch, load unit, store unit) and the single transaction port of the memory controller.
- Selects one client at a time and holds the downstream request stable until the controller signals done.
- Returns the read data and a one-cycle done pulse to the granted client.
- Handles pipeline flush of in-flight fetches and prevents fetch starvation.

Parameters:
- STARVE_LIMIT, 4, number of consecutive lost arbitrations after which a waiting fetch is promoted (aging feature only)
- CNT_W, 3, width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- flush  in  1  branch/exception flush; cancels pending or in-flight fetch
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  32  fetch byte address
- if_done  out  1  one-cycle fetch completion pulse
- if_data  out  32  fetched word, valid with if_done
- ld_req  in  1  load request, level
- ld_addr  in  32  load address
- ld_size  in  2  0=byte, 1=half, 2=word
- ld_done  out  1  load completion pulse
- ld_data  out  32  raw loaded word (extension done by load unit)
- st_req  in  1  store request, level
- st_addr  in  32  store address
- st_size  in  2  as ld_size
- st_data  in  32  store data, little-endian in low bytes
- st_done  out  1  store completion pulse
- m_req  out  1  downstream transaction valid
- m_we  out  1  1=write, 0=read
- m_inst  out  1  1=instruction fetch transaction
- m_addr  out  32  downstream address
- m_size  out  2  downstream size
- m_wdata  out  32  downstream write data
- m_done  in  1  controller completion pulse
- m_rdata  in  32  controller read data, valid with m_done

Behaviour:
- Reset: all outputs 0, state IDLE, starvation counter 0, grant register NONE. Reset mid-transaction drops m_req on the same edge; a later m_done is ignored.
- States:
  - IDLE: arbitrate.
  - BUSY: m_req high, waiting for m_done.
  - DRAIN: flushed fetch still in flight; waiting for m_done, result discarded.
  - RESP: one cycle, client done pulse is high.
- IDLE -> BUSY on any eligible request.
- Priority: st > ld > if.
- Eligibility masks:
  - A client whose done output is high this cycle is ineligible; this blocks re-grant of a stale held request.
  - if_req is ineligible while flush=1.
- On grant, m_addr/m_size/m_wdata/m_we/m_inst are latched from the winning client. They stay constant through BUSY regardless of client input changes. Fetch forces m_size=2, m_we=0, m_inst=1.
- Latency: request sampled at edge N -> m_req=1 from N+1. m_done at cycle k -> m_req=0 and client done=1 with data from k+1 (RESP). State returns to IDLE at k+2; earliest next m_req is at k+3.
- m_done while state is IDLE or RESP is ignored.
- Flush:
  - flush in BUSY with a fetch grant -> DRAIN. m_req stays high until m_done, then IDLE with no if_done.
  - flush in BUSY with a load/store grant has no effect.
  - flush in RESP for a fetch suppresses that if_done pulse.
- if_data/ld_data hold their last value between pulses. Only one done output is high in any cycle.
- Starvation counter: increments, saturating, on each IDLE grant given to ld/st while if_req is eligible. Clears on fetch grant or when if_req=0.

Optional Feature:
- MEM_ARB_AGING_EN defined: when counter >= STARVE_LIMIT, the eligible fetch wins over ld/st in the next IDLE arbitration.
- Not defined: strict priority st > ld > if; counter logic removed.

Decomposition:
- Shared package/config include: state encodings (IDLE, BUSY, DRAIN, RESP), client IDs (NONE, IF, LD, ST), size encodings, Zero/True/False constants.
- One natural sub-module, mem_arb_pick: combinational priority selector with mask and aging input, producing a one-hot grant.

Test Plan:
- st_req+ld_req+if_req asserted together at edge N -> m_we=1 from N+1. m_done at N+3 -> st_done at N+4. Then ld granted; if granted only after ld_done.
- ld_req addr 0x1004 size 2, m_done with m_rdata 0xDEADBEEF -> ld_done one cycle with ld_data 0xDEADBEEF. Held ld_req during done is not re-granted.
- Fetch addr 0x0100 granted, flush pulsed during BUSY -> m_req stays until m_done, no if_done. Next fetch addr 0x0200 goes out with m_inst=1.
- rst asserted in BUSY -> m_req=0 next cycle. m_done arriving afterwards produces no done pulse.
- Aging, with MEM_ARB_AGING_EN, STARVE_LIMIT=4: continuous ld_req plus if_req -> fetch granted on the 5th arbitration. Without the macro, fetch is never granted while ld_req stays high.
- Client changes st_addr 0x20000 -> 0x30000 during BUSY -> m_addr remains 0x20000 until m_done.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: FSM states, client IDs,
// transfer sizes, grant vector bit positions and common constants.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DRAIN,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        CL_NONE,
        CL_IF,
        CL_LD,
        CL_ST
    } client_t;

    localparam logic [1:0]  SZ_BYTE = 2'd0;
    localparam logic [1:0]  SZ_HALF = 2'd1;
    localparam logic [1:0]  SZ_WORD = 2'd2;

    // Bit positions inside request / mask / grant vectors.
    localparam int          GI_IF   = 0;
    localparam int          GI_LD   = 1;
    localparam int          GI_ST   = 2;

    localparam logic [31:0] ZERO32  = 32'd0;
    localparam logic        TRUE    = 1'b1;
    localparam logic        FALSE   = 1'b0;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational priority selector: st > ld > if, with masking and an
// aging override that lets an eligible fetch win.
//   i_req  : raw requests {st, ld, if}
//   i_mask : per-client ineligible flags, same bit order
//   i_age  : fetch has been starved long enough to be promoted
//   o_gnt  : one-hot grant (all zero when nothing is eligible)
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic [2:0] i_req,
    input  logic [2:0] i_mask,
    input  logic       i_age,
    output logic [2:0] o_gnt
);

    logic [2:0] w_elig;

    assign w_elig = i_req & ~i_mask;

    always_comb begin
        o_gnt = 3'b000;
        if (i_age && w_elig[GI_IF]) begin
            o_gnt[GI_IF] = TRUE;
        end else if (w_elig[GI_ST]) begin
            o_gnt[GI_ST] = TRUE;
        end else if (w_elig[GI_LD]) begin
            o_gnt[GI_LD] = TRUE;
        end else if (w_elig[GI_IF]) begin
            o_gnt[GI_IF] = TRUE;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Schedules fetch / load / store clients onto one memory transaction
// port. Holds the downstream request stable until m_done, returns data
// with a one-cycle done pulse, and drains flushed fetches silently.
// Ports: clk, rst (sync, active-high), flush; if_*, ld_*, st_* client
// side; m_* controller side.
// Build option: define MEM_ARB_AGING_EN to promote a starved fetch
// after STARVE_LIMIT lost arbitrations (otherwise strict priority).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic [1:0]  ld_size,
    output logic        ld_done,
    output logic [31:0] ld_data,
    input  logic        st_req,
    input  logic [31:0] st_addr,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_data,
    output logic        st_done,
    output logic        m_req,
    output logic        m_we,
    output logic        m_inst,
    output logic [31:0] m_addr,
    output logic [1:0]  m_size,
    output logic [31:0] m_wdata,
    input  logic        m_done,
    input  logic [31:0] m_rdata
);

    state_t      r_state;
    state_t      w_state_nx;
    client_t     r_gnt;
    logic        r_we;
    logic        r_inst;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic [31:0] r_wdata;
    logic [31:0] r_if_data;
    logic [31:0] r_ld_data;
    logic [2:0]  w_req;
    logic [2:0]  w_mask;
    logic [2:0]  w_pick;
    logic        w_age;
    logic        w_flush_if;
    logic        w_grant;

    assign w_req      = {st_req, ld_req, if_req};
    assign w_mask     = {st_done, ld_done, if_done | flush};
    assign w_flush_if = flush && (r_gnt == CL_IF);
    assign w_grant    = (r_state == S_IDLE) && (|w_pick);

    mem_arb_pick u_pick (
        .i_req  (w_req),
        .i_mask (w_mask),
        .i_age  (w_age),
        .o_gnt  (w_pick)
    );

`ifdef MEM_ARB_AGING_EN
    logic [CNT_W-1:0] r_cnt;
    logic             w_if_elig;

    assign w_if_elig = if_req && !flush && !if_done;
    assign w_age     = (r_cnt >= CNT_W'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!if_req) begin
            r_cnt <= '0;
        end else if (w_grant && w_pick[GI_IF]) begin
            r_cnt <= '0;
        end else if (w_grant && w_if_elig && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    logic [CNT_W-1:0] w_unused_lim;

    assign w_unused_lim = CNT_W'(STARVE_LIMIT);
    assign w_age        = FALSE;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (|w_pick) w_state_nx = S_BUSY;
            end
            S_BUSY: begin
                // Flush coinciding with completion skips DRAIN entirely.
                if (m_done) begin
                    w_state_nx = w_flush_if ? S_IDLE : S_RESP;
                end else if (w_flush_if) begin
                    w_state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (m_done) w_state_nx = S_IDLE;
            end
            S_RESP: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign if_done = (r_state == S_RESP) && (r_gnt == CL_IF) && !flush;
    assign ld_done = (r_state == S_RESP) && (r_gnt == CL_LD);
    assign st_done = (r_state == S_RESP) && (r_gnt == CL_ST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt     <= CL_NONE;
            r_we      <= FALSE;
            r_inst    <= FALSE;
            r_addr    <= ZERO32;
            r_size    <= SZ_BYTE;
            r_wdata   <= ZERO32;
            r_if_data <= ZERO32;
            r_ld_data <= ZERO32;
        end else begin
            if (w_grant) begin
                unique case (1'b1)
                    w_pick[GI_ST]: begin
                        r_gnt   <= CL_ST;
                        r_we    <= TRUE;
                        r_inst  <= FALSE;
                        r_addr  <= st_addr;
                        r_size  <= st_size;
                        r_wdata <= st_data;
                    end
                    w_pick[GI_LD]: begin
                        r_gnt   <= CL_LD;
                        r_we    <= FALSE;
                        r_inst  <= FALSE;
                        r_addr  <= ld_addr;
                        r_size  <= ld_size;
                        r_wdata <= ZERO32;
                    end
                    default: begin
                        r_gnt   <= CL_IF;
                        r_we    <= FALSE;
                        r_inst  <= TRUE;
                        r_addr  <= if_addr;
                        r_size  <= SZ_WORD;
                        r_wdata <= ZERO32;
                    end
                endcase
            end else if (r_state != S_IDLE && w_state_nx == S_IDLE) begin
                r_gnt <= CL_NONE;
            end
            if (r_state == S_BUSY && m_done) begin
                if (r_gnt == CL_IF && !flush) r_if_data <= m_rdata;
                if (r_gnt == CL_LD) r_ld_data <= m_rdata;
            end
        end
    end

    assign m_req   = (r_state == S_BUSY) || (r_state == S_DRAIN);
    assign m_we    = r_we;
    assign m_inst  = r_inst;
    assign m_addr  = r_addr;
    assign m_size  = r_size;
    assign m_wdata = r_wdata;
    assign if_data = r_if_data;
    assign ld_data = r_ld_data;

endmodule
